// File: rtl/rs_int_pkg.sv
// Shared constants for the integer reservation station: default rename-tag,
// operand and opcode widths plus dispatch-width constants.
package rs_int_pkg;

  localparam int TAG_W_DEF    = 6;
  localparam int DATA_W_DEF   = 32;
  localparam int OP_W_DEF     = 4;
  localparam int RS_DP_NUM    = 2;
  localparam int DP_NUM_WIDTH = 1;

endpackage

// File: rtl/rs_int_req_arbiter.sv
// Fixed-priority request arbiter: grants the lowest-index active request and
// reports its index together with a valid flag.
module req_arbiter
  import rs_int_pkg::*;
#(
  parameter int REQ_NUM = 2,
  parameter int ACK_SEL = 1
) (
  input  logic [REQ_NUM-1:0] i_req,
  output logic               o_vld,
  output logic [ACK_SEL-1:0] o_sel
);

  assign o_vld = |i_req;

  // Scan downwards so the lowest set index is the last assignment to stick.
  always_comb begin
    o_sel = '0;
    for (int i = REQ_NUM - 1; i >= 0; i--) begin
      if (i_req[i]) o_sel = ACK_SEL'(i);
    end
  end

endmodule

// File: rtl/rs_int.sv
// Integer reservation station: two dispatch slots, two CDB wakeup ports,
// in-order-agnostic single issue of the lowest-index ready entry.
module rs_int
  import rs_int_pkg::*;
#(
  parameter int RS_ENT_NUM = 2,
  parameter int RS_ENT_SEL = 1,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int OP_W       = OP_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_flush,
  input  logic                  i_we_1,
  input  logic [RS_ENT_SEL-1:0] i_sel_1,
  input  logic [OP_W-1:0]       i_op_1,
  input  logic [TAG_W-1:0]      i_dst_1,
  input  logic [DATA_W-1:0]     i_src1_1,
  input  logic [DATA_W-1:0]     i_src2_1,
  input  logic                  i_src1_vld_1,
  input  logic                  i_src2_vld_1,
  input  logic                  i_we_2,
  input  logic [RS_ENT_SEL-1:0] i_sel_2,
  input  logic [OP_W-1:0]       i_op_2,
  input  logic [TAG_W-1:0]      i_dst_2,
  input  logic [DATA_W-1:0]     i_src1_2,
  input  logic [DATA_W-1:0]     i_src2_2,
  input  logic                  i_src1_vld_2,
  input  logic                  i_src2_vld_2,
  input  logic                  i_cdb_vld_1,
  input  logic [TAG_W-1:0]      i_cdb_tag_1,
  input  logic [DATA_W-1:0]     i_cdb_data_1,
  input  logic                  i_cdb_vld_2,
  input  logic [TAG_W-1:0]      i_cdb_tag_2,
  input  logic [DATA_W-1:0]     i_cdb_data_2,
  output logic [RS_ENT_NUM-1:0] o_busy_vec,
  output logic                  o_issue_vld,
  input  logic                  i_issue_rdy,
  output logic [OP_W-1:0]       o_issue_op,
  output logic [DATA_W-1:0]     o_issue_src1,
  output logic [DATA_W-1:0]     o_issue_src2,
  output logic [TAG_W-1:0]      o_issue_dst
);

  logic [RS_ENT_NUM-1:0] w_busy;
  logic [RS_ENT_NUM-1:0] w_ready;
  logic [OP_W-1:0]       w_op   [RS_ENT_NUM];
  logic [TAG_W-1:0]      w_dst  [RS_ENT_NUM];
  logic [DATA_W-1:0]     w_src1 [RS_ENT_NUM];
  logic [DATA_W-1:0]     w_src2 [RS_ENT_NUM];
  logic [RS_ENT_SEL-1:0] w_iss_sel;
  logic                  w_any_rdy;
  logic                  w_fire;

  // Returns {vld, data}: a pending tag is replaced by CDB data on a match,
  // port 1 taking precedence. Serves both dispatch bypass and wakeup.
  function automatic logic [DATA_W:0] resolve(
    input logic              vld,
    input logic [DATA_W-1:0] val
  );
    if (vld) return {1'b1, val};
    if (i_cdb_vld_1 && (i_cdb_tag_1 == val[TAG_W-1:0])) return {1'b1, i_cdb_data_1};
    if (i_cdb_vld_2 && (i_cdb_tag_2 == val[TAG_W-1:0])) return {1'b1, i_cdb_data_2};
    return {1'b0, val};
  endfunction

  assign w_fire = w_any_rdy & i_issue_rdy;

  for (genvar gi = 0; gi < RS_ENT_NUM; gi++) begin : gen_ent
    logic              r_busy;
    logic              r_src1_vld;
    logic              r_src2_vld;
    logic [OP_W-1:0]   r_op;
    logic [TAG_W-1:0]  r_dst;
    logic [DATA_W-1:0] r_src1;
    logic [DATA_W-1:0] r_src2;
    logic              w_wr1;
    logic              w_wr2;
    logic              w_iss;

    assign w_wr1 = i_we_1 && (i_sel_1 == RS_ENT_SEL'(gi));
    assign w_wr2 = i_we_2 && (i_sel_2 == RS_ENT_SEL'(gi));
    assign w_iss = w_fire && (w_iss_sel == RS_ENT_SEL'(gi));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_busy <= 1'b0;
      else if (i_flush)       r_busy <= 1'b0;
      else if (w_wr1 | w_wr2) r_busy <= 1'b1;
      else if (w_iss)         r_busy <= 1'b0;
    end

    // Payload needs no reset: it is only observed through a set busy bit.
    always_ff @(posedge clk) begin
      if (w_wr1) begin
        r_op                 <= i_op_1;
        r_dst                <= i_dst_1;
        {r_src1_vld, r_src1} <= resolve(i_src1_vld_1, i_src1_1);
        {r_src2_vld, r_src2} <= resolve(i_src2_vld_1, i_src2_1);
      end else if (w_wr2) begin
        r_op                 <= i_op_2;
        r_dst                <= i_dst_2;
        {r_src1_vld, r_src1} <= resolve(i_src1_vld_2, i_src1_2);
        {r_src2_vld, r_src2} <= resolve(i_src2_vld_2, i_src2_2);
      end else if (r_busy) begin
        {r_src1_vld, r_src1} <= resolve(r_src1_vld, r_src1);
        {r_src2_vld, r_src2} <= resolve(r_src2_vld, r_src2);
      end
    end

    assign w_busy[gi]  = r_busy;
    assign w_ready[gi] = r_busy & r_src1_vld & r_src2_vld;
    assign w_op[gi]    = r_op;
    assign w_dst[gi]   = r_dst;
    assign w_src1[gi]  = r_src1;
    assign w_src2[gi]  = r_src2;
  end

  req_arbiter #(
    .REQ_NUM (RS_ENT_NUM),
    .ACK_SEL (RS_ENT_SEL)
  ) u_arb (
    .i_req (w_ready),
    .o_vld (w_any_rdy),
    .o_sel (w_iss_sel)
  );

  assign o_busy_vec   = w_busy;
  assign o_issue_vld  = w_any_rdy;
  assign o_issue_op   = w_op[w_iss_sel];
  assign o_issue_dst  = w_dst[w_iss_sel];
  assign o_issue_src1 = w_src1[w_iss_sel];
  assign o_issue_src2 = w_src2[w_iss_sel];

endmodule

// File: tb/tb_rs_int.sv
// Directed testbench for rs_int: dispatch, bypass, wakeup, issue order,
// flush and asynchronous reset, each scenario checked inline.
module tb_rs_int;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        we_1, we_2;
  logic [0:0]  sel_1, sel_2;
  logic [3:0]  op_1, op_2;
  logic [5:0]  dst_1, dst_2;
  logic [31:0] s1_1, s2_1, s1_2, s2_2;
  logic        v1_1, v2_1, v1_2, v2_2;
  logic        cv_1, cv_2;
  logic [5:0]  ct_1, ct_2;
  logic [31:0] cd_1, cd_2;
  logic [1:0]  busy_vec;
  logic        iss_vld;
  logic        iss_rdy;
  logic [3:0]  iss_op;
  logic [31:0] iss_src1, iss_src2;
  logic [5:0]  iss_dst;

  int n_total;
  int n_bad;

  rs_int dut (
    .clk          (clk),
    .rst          (rst),
    .i_flush      (flush),
    .i_we_1       (we_1),
    .i_sel_1      (sel_1),
    .i_op_1       (op_1),
    .i_dst_1      (dst_1),
    .i_src1_1     (s1_1),
    .i_src2_1     (s2_1),
    .i_src1_vld_1 (v1_1),
    .i_src2_vld_1 (v2_1),
    .i_we_2       (we_2),
    .i_sel_2      (sel_2),
    .i_op_2       (op_2),
    .i_dst_2      (dst_2),
    .i_src1_2     (s1_2),
    .i_src2_2     (s2_2),
    .i_src1_vld_2 (v1_2),
    .i_src2_vld_2 (v2_2),
    .i_cdb_vld_1  (cv_1),
    .i_cdb_tag_1  (ct_1),
    .i_cdb_data_1 (cd_1),
    .i_cdb_vld_2  (cv_2),
    .i_cdb_tag_2  (ct_2),
    .i_cdb_data_2 (cd_2),
    .o_busy_vec   (busy_vec),
    .o_issue_vld  (iss_vld),
    .i_issue_rdy  (iss_rdy),
    .o_issue_op   (iss_op),
    .o_issue_src1 (iss_src1),
    .o_issue_src2 (iss_src2),
    .o_issue_dst  (iss_dst)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Illegal dispatch patterns must never be produced by this stimulus.
  always @(posedge clk) begin
    if (!rst && !flush) begin
      assert (!(we_1 && we_2 && sel_1 == sel_2)) else $error("illegal dual write to entry %0d", sel_1);
      assert (!(we_1 && busy_vec[sel_1])) else $error("slot 1 writes busy entry %0d", sel_1);
      assert (!(we_2 && busy_vec[sel_2])) else $error("slot 2 writes busy entry %0d", sel_2);
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    flush = 0; we_1 = 0; we_2 = 0; sel_1 = 0; sel_2 = 0;
    op_1 = 0; op_2 = 0; dst_1 = 0; dst_2 = 0;
    s1_1 = 0; s2_1 = 0; s1_2 = 0; s2_2 = 0;
    v1_1 = 0; v2_1 = 0; v1_2 = 0; v2_2 = 0;
    cv_1 = 0; cv_2 = 0; ct_1 = 0; ct_2 = 0; cd_1 = 0; cd_2 = 0;
  endtask

  task automatic drive_w1(input logic sel, input logic [3:0] op, input logic [5:0] dst,
                          input logic [31:0] a, input logic va, input logic [31:0] b, input logic vb);
    we_1 = 1; sel_1 = sel; op_1 = op; dst_1 = dst; s1_1 = a; v1_1 = va; s2_1 = b; v2_1 = vb;
  endtask

  task automatic drive_w2(input logic sel, input logic [3:0] op, input logic [5:0] dst,
                          input logic [31:0] a, input logic va, input logic [31:0] b, input logic vb);
    we_2 = 1; sel_2 = sel; op_2 = op; dst_2 = dst; s1_2 = a; v1_2 = va; s2_2 = b; v2_2 = vb;
  endtask

  task automatic test_reset();
    rst = 1; iss_rdy = 0; clear_inputs();
    #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL reset_busy got=%b exp=00", busy_vec); end
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL reset_vld got=%b exp=0", iss_vld); end
    @(negedge clk); @(negedge clk);
    rst = 0;
  endtask

  task automatic test_write_issue();
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    drive_w1(0, 4'd3, 6'd5, 32'h11, 1, 32'h22, 1);
    @(posedge clk); #1;
    n_total++; if (iss_vld !== 1'b1) begin n_bad++; $display("FAIL wi_vld got=%b exp=1", iss_vld); end
    n_total++; if (iss_op !== 4'd3) begin n_bad++; $display("FAIL wi_op got=%0d exp=3", iss_op); end
    n_total++; if (iss_dst !== 6'd5) begin n_bad++; $display("FAIL wi_dst got=%0d exp=5", iss_dst); end
    n_total++; if (iss_src1 !== 32'h11 || iss_src2 !== 32'h22) begin n_bad++; $display("FAIL wi_src got=%h/%h exp=11/22", iss_src1, iss_src2); end
    n_total++; if (busy_vec !== 2'b01) begin n_bad++; $display("FAIL wi_busy got=%b exp=01", busy_vec); end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL wi_busy_after got=%b exp=00", busy_vec); end
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL wi_vld_after got=%b exp=0", iss_vld); end
  endtask

  task automatic test_wakeup();
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    drive_w2(1, 4'd7, 6'd8, 32'd9, 0, 32'h33, 1);
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b10) begin n_bad++; $display("FAIL wk_busy got=%b exp=10", busy_vec); end
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL wk_pending got=%b exp=0", iss_vld); end
    @(negedge clk); clear_inputs(); cv_2 = 1; ct_2 = 6'd10; cd_2 = 32'hDEAD;
    @(posedge clk); #1;
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL wk_wrong_tag got=%b exp=0", iss_vld); end
    @(negedge clk); clear_inputs(); cv_1 = 1; ct_1 = 6'd9; cd_1 = 32'hABCD;
    #1;
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL wk_comb_path got=%b exp=0", iss_vld); end
    @(posedge clk); #1;
    n_total++; if (iss_vld !== 1'b1) begin n_bad++; $display("FAIL wk_vld got=%b exp=1", iss_vld); end
    n_total++; if (iss_src1 !== 32'hABCD) begin n_bad++; $display("FAIL wk_src1 got=%h exp=abcd", iss_src1); end
    n_total++; if (iss_src2 !== 32'h33 || iss_op !== 4'd7 || iss_dst !== 6'd8) begin n_bad++; $display("FAIL wk_fields got=%h/%0d/%0d exp=33/7/8", iss_src2, iss_op, iss_dst); end
    @(negedge clk); clear_inputs();
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL wk_drain got=%b exp=00", busy_vec); end
  endtask

  task automatic test_bypass();
    @(negedge clk); clear_inputs(); iss_rdy = 0;
    drive_w1(0, 4'd4, 6'd6, 32'h44, 1, 32'd4, 0);
    cv_2 = 1; ct_2 = 6'd4; cd_2 = 32'h55;
    @(posedge clk); #1;
    n_total++; if (iss_vld !== 1'b1) begin n_bad++; $display("FAIL bp_vld got=%b exp=1", iss_vld); end
    n_total++; if (iss_src2 !== 32'h55) begin n_bad++; $display("FAIL bp_src2 got=%h exp=55", iss_src2); end
    n_total++; if (iss_src1 !== 32'h44) begin n_bad++; $display("FAIL bp_src1 got=%h exp=44", iss_src1); end
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL bp_drain got=%b exp=00", busy_vec); end
  endtask

  task automatic test_cdb_priority();
    @(negedge clk); clear_inputs(); iss_rdy = 0;
    drive_w1(1, 4'd9, 6'd3, 32'd12, 0, 32'h66, 1);
    @(negedge clk); clear_inputs();
    cv_1 = 1; ct_1 = 6'd12; cd_1 = 32'h111;
    cv_2 = 1; ct_2 = 6'd12; cd_2 = 32'h222;
    @(posedge clk); #1;
    n_total++; if (iss_vld !== 1'b1) begin n_bad++; $display("FAIL pri_vld got=%b exp=1", iss_vld); end
    n_total++; if (iss_src1 !== 32'h111) begin n_bad++; $display("FAIL pri_src1 got=%h exp=111", iss_src1); end
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL pri_drain got=%b exp=00", busy_vec); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk); clear_inputs(); iss_rdy = 0;
    drive_w1(1, 4'd2, 6'd20, 32'h3, 1, 32'h4, 1);
    drive_w2(0, 4'd1, 6'd10, 32'h1, 1, 32'h2, 1);
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b11) begin n_bad++; $display("FAIL b2b_busy0 got=%b exp=11", busy_vec); end
    n_total++; if (iss_vld !== 1'b1 || iss_dst !== 6'd10) begin n_bad++; $display("FAIL b2b_first got=%b/%0d exp=1/10", iss_vld, iss_dst); end
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b10) begin n_bad++; $display("FAIL b2b_busy1 got=%b exp=10", busy_vec); end
    n_total++; if (iss_vld !== 1'b1 || iss_dst !== 6'd20 || iss_op !== 4'd2) begin n_bad++; $display("FAIL b2b_second got=%b/%0d/%0d exp=1/20/2", iss_vld, iss_dst, iss_op); end
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL b2b_busy2 got=%b exp=00", busy_vec); end
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL b2b_vld2 got=%b exp=0", iss_vld); end
  endtask

  task automatic test_full_flush();
    @(negedge clk); clear_inputs(); iss_rdy = 0;
    drive_w1(0, 4'd5, 6'd40, 32'd20, 0, 32'h7, 1);
    drive_w2(1, 4'd6, 6'd41, 32'd21, 0, 32'h8, 1);
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b11) begin n_bad++; $display("FAIL full_busy got=%b exp=11", busy_vec); end
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b11 || iss_vld !== 1'b0) begin n_bad++; $display("FAIL full_hold got=%b/%b exp=11/0", busy_vec, iss_vld); end
    @(negedge clk); cv_1 = 1; ct_1 = 6'd21; cd_1 = 32'h77;
    @(posedge clk); #1;
    n_total++; if (iss_vld !== 1'b1 || iss_dst !== 6'd41 || iss_src1 !== 32'h77) begin n_bad++; $display("FAIL full_wake got=%b/%0d/%h exp=1/41/77", iss_vld, iss_dst, iss_src1); end
    @(negedge clk); clear_inputs(); flush = 1; iss_rdy = 1;
    drive_w1(0, 4'd1, 6'd1, 32'h1, 1, 32'h1, 1);
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL flush_busy got=%b exp=00", busy_vec); end
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL flush_vld got=%b exp=0", iss_vld); end
    @(negedge clk); clear_inputs(); iss_rdy = 0;
    drive_w1(1, 4'hA, 6'h2A, 32'h9, 1, 32'h9, 1);
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b10 || iss_vld !== 1'b1 || iss_op !== 4'hA) begin n_bad++; $display("FAIL post_flush got=%b/%b/%h exp=10/1/a", busy_vec, iss_vld, iss_op); end
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL post_flush_drain got=%b exp=00", busy_vec); end
  endtask

  task automatic test_async_reset();
    @(negedge clk); clear_inputs(); iss_rdy = 0;
    drive_w1(0, 4'd2, 6'd30, 32'd30, 0, 32'h1, 1);
    drive_w2(1, 4'd3, 6'd31, 32'd31, 0, 32'h1, 1);
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b11) begin n_bad++; $display("FAIL ar_busy_pre got=%b exp=11", busy_vec); end
    @(negedge clk); clear_inputs();
    drive_w2(0, 4'd5, 6'd7, 32'h5, 1, 32'h6, 1);
    #2 rst = 1;
    #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL ar_busy_async got=%b exp=00", busy_vec); end
    n_total++; if (iss_vld !== 1'b0) begin n_bad++; $display("FAIL ar_vld_async got=%b exp=0", iss_vld); end
    #1 rst = 0;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b01 || iss_vld !== 1'b1 || iss_dst !== 6'd7) begin n_bad++; $display("FAIL ar_first_write got=%b/%b/%0d exp=01/1/7", busy_vec, iss_vld, iss_dst); end
    @(negedge clk); clear_inputs(); iss_rdy = 1;
    @(posedge clk); #1;
    n_total++; if (busy_vec !== 2'b00) begin n_bad++; $display("FAIL ar_drain got=%b exp=00", busy_vec); end
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    test_reset();
    test_write_issue();
    test_wakeup();
    test_bypass();
    test_cdb_priority();
    test_back_to_back();
    test_full_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
